// File: rtl/ps2_tx_mux_pkg.sv
// Shared state encoding and frame constants for the multi-channel PS/2 device transmitter.
package ps2_tx_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  // D0..D7 share ST_DATA; a separate 3-bit counter selects the bit.
  typedef logic [2:0] ps2_state_t;
  localparam ps2_state_t ST_IDLE   = 3'd0;
  localparam ps2_state_t ST_START  = 3'd1;
  localparam ps2_state_t ST_DATA   = 3'd2;
  localparam ps2_state_t ST_PARITY = 3'd3;
  localparam ps2_state_t ST_STOP   = 3'd4;
  localparam ps2_state_t ST_HOLD   = 3'd5;

endpackage

// File: rtl/ps2_tx_mux_if.sv
// Host-side byte write port shared by all PS/2 channels, plus per-channel FIFO status.
interface ps2_tx_mux_if #(
  parameter int CHANNELS = 2,
  parameter int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                wr_en;
  logic [CHAN_W-1:0]   wr_chan;
  logic [7:0]          wr_data;
  logic [CHANNELS-1:0] ovf_clr;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] overflow;

  modport master (output wr_en, wr_chan, wr_data, ovf_clr, input full, overflow);
  modport slave  (input wr_en, wr_chan, wr_data, ovf_clr, output full, overflow);
endinterface

// File: rtl/ps2_tx_chan.sv
// One PS/2 device-side transmitter: byte FIFO, frame FSM, sticky overflow.
// Host-inhibit abort/retry is compiled in with PS2_TX_INHIBIT_EN.
//
// state     | meaning
// IDLE      | ps2_clk released high, waiting for a queued byte on tick
// START     | start bit (0) on ps2_data
// DATA      | data bit bit_cnt (D0..D7), LSB first
// PARITY    | odd parity bit on ps2_data
// STOP      | stop bit (1); FIFO head popped when this period ends
// HOLD      | trailing clock period before returning to IDLE
module ps2_tx_chan
  import ps2_tx_pkg::*;
#(
  parameter int DEPTH_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       clk_int,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  input  logic       ps2_clk_in,
  output logic       full,
  output logic       overflow,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int                DEPTH   = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] DEPTH_P = (DEPTH_BITS + 1)'(DEPTH);

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_BITS:0] wptr, rptr;
  logic                empty, push, pop;
  ps2_state_t          state;
  logic [2:0]          bit_cnt;
  logic [7:0]          shreg;
  logic                parity, data_q;
  logic                inhibit, abort;

  assign full  = (wptr - rptr) == DEPTH_P;
  assign empty = (wptr == rptr);
  assign push  = wr_en && !full;
  assign pop   = tick && (state == ST_STOP) && !abort;

  always_ff @(posedge clk_sys) begin
    if (push) mem[wptr[DEPTH_BITS-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

`ifdef PS2_TX_INHIBIT_EN
  logic [1:0] clk_in_sync;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) clk_in_sync <= 2'b11;
    else          clk_in_sync <= {clk_in_sync[0], ps2_clk_in};
  end

  // The host can only win the line while we are releasing it high.
  assign inhibit = !clk_in_sync[1];
  assign abort   = inhibit && clk_int && (state != ST_IDLE) && (state != ST_HOLD);
`else
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
  assign inhibit       = 1'b0;
  assign abort         = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      parity  <= 1'b1;
      data_q  <= 1'b1;
    end else if (abort) begin
      state  <= ST_IDLE;
      data_q <= 1'b1;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!empty && !inhibit) begin
            shreg  <= mem[rptr[DEPTH_BITS-1:0]];
            parity <= 1'b1;
            data_q <= PS2_START;
            state  <= ST_START;
          end
        end
        ST_START: begin
          data_q  <= shreg[0];
          parity  <= parity ^ shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= 3'd0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) begin
            data_q <= parity;
            state  <= ST_PARITY;
          end else begin
            data_q  <= shreg[0];
            parity  <= parity ^ shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          data_q <= PS2_STOP;
          state  <= ST_STOP;
        end
        ST_STOP: state <= ST_HOLD;
        ST_HOLD: state <= ST_IDLE;
        default: begin
          data_q <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign ps2_clk  = (state != ST_IDLE) ? clk_int : 1'b1;
  assign ps2_data = data_q;

endmodule

// File: rtl/ps2_tx_mux.sv
// CHANNELS independent PS/2 device transmitters behind one shared byte write port
// and one shared PS/2 clock divider. Optional host inhibit: PS2_TX_INHIBIT_EN.
module ps2_tx_mux
  import ps2_tx_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DEPTH_BITS = 3,
  parameter int PS2DIV     = 1000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  ps2_tx_mux_if.slave         host,
  input  logic [CHANNELS-1:0] ps2_clk_in,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] ps2_clk,
  output logic [CHANNELS-1:0] ps2_data
);

  localparam int               CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int               CNT_W   = (PS2DIV > 0) ? $clog2(PS2DIV + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PS2DIV);

  logic [CNT_W-1:0]    cnt;
  logic                clk_int;
  logic                tick;
  logic [CHANNELS-1:0] full_v, ovf_v;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      clk_int <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      clk_int <= ~clk_int;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Active in the cycle whose closing edge raises clk_int, so data moves with the clock rise.
  assign tick = (cnt == CNT_MAX) && !clk_int;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic wr_hit;
    assign wr_hit = host.wr_en && (host.wr_chan == CHAN_W'(g));

    ps2_tx_chan #(.DEPTH_BITS(DEPTH_BITS)) u_chan (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .tick       (tick),
      .clk_int    (clk_int),
      .wr_en      (wr_hit),
      .wr_data    (host.wr_data),
      .ovf_clr    (host.ovf_clr[g]),
      .ps2_clk_in (ps2_clk_in[g]),
      .full       (full_v[g]),
      .overflow   (ovf_v[g]),
      .busy       (busy[g]),
      .ps2_clk    (ps2_clk[g]),
      .ps2_data   (ps2_data[g])
    );
  end

  assign host.full     = full_v;
  assign host.overflow = ovf_v;

endmodule

// File: tb/tb_ps2_tx_mux.sv
// Scoreboard bench for ps2_tx_mux: queued bytes are compared against frames decoded
// from ps2_clk/ps2_data; inhibit scenario runs when PS2_TX_INHIBIT_EN is defined.
module tb_ps2_tx_mux;

  localparam int CH    = 2;
  localparam int CHW   = 1;
  localparam int DEPTH = 8;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic [CH-1:0] ps2_clk_in;
  logic [CH-1:0] busy, ps2_clk, ps2_data;

  ps2_tx_mux_if #(.CHANNELS(CH)) host_if ();

  ps2_tx_mux #(.CHANNELS(CH), .DEPTH_BITS(3), .PS2DIV(4)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .host       (host_if),
    .ps2_clk_in (ps2_clk_in),
    .busy       (busy),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  logic [7:0]  exp_q [CH][$];
  logic [CH-1:0] ovf_model = '0;
  int          bitpos [CH];
  logic [10:0] frame_sh [CH];
  logic [10:0] last_frame [CH];
  int          frames [CH];
  logic        prev_clk [CH];
  bit          par_en = 1'b0;
  int          overlap = 0;
  int          phase_err = 0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      bitpos[c] = 0; frames[c] = 0; prev_clk[c] = 1'b1;
      frame_sh[c] = '0; last_frame[c] = '0;
    end
  end

  // Frame decoder: samples ps2_data on each ps2_clk fall, away from clk_sys rising edges.
  always @(negedge clk_sys) begin
    logic [7:0] exp_b;
    for (int c = 0; c < CH; c++) begin
      if (!reset_n || !busy[c]) begin
        bitpos[c] = 0;
      end else if (prev_clk[c] && !ps2_clk[c]) begin
        if (bitpos[c] != 0 || ps2_data[c] == 1'b0) begin
          frame_sh[c][bitpos[c]] = ps2_data[c];
          bitpos[c]++;
          if (bitpos[c] == 11) begin
            bitpos[c]     = 0;
            last_frame[c] = frame_sh[c];
            frames[c]++;
            if (exp_q[c].size() == 0) begin
              check_eq($sformatf("unexpected_frame_ch%0d", c), {21'd0, frame_sh[c]}, 32'd0);
            end else begin
              exp_b = exp_q[c].pop_front();
              check_eq($sformatf("frame_ch%0d", c), {21'd0, frame_sh[c]}, {21'd0, frame_bits(exp_b)});
            end
          end
        end
      end
      prev_clk[c] = ps2_clk[c];
    end
    if (par_en && busy[0] && busy[1]) begin
      overlap++;
      if (ps2_clk[0] !== ps2_clk[1]) phase_err++;
    end
  end

  // Called just after a clk_sys fall; the write lands on the next rise.
  task automatic do_write(input int ch, input logic [7:0] d, input logic [CH-1:0] clr);
    bit dropped;
    host_if.wr_en   = 1'b1;
    host_if.wr_chan = CHW'(ch);
    host_if.wr_data = d;
    host_if.ovf_clr = clr;
    dropped = (exp_q[ch].size() >= DEPTH);
    if (!dropped) exp_q[ch].push_back(d);
    for (int c = 0; c < CH; c++)
      if (clr[c] && !(dropped && c == ch)) ovf_model[c] = 1'b0;
    if (dropped) ovf_model[ch] = 1'b1;
    @(negedge clk_sys);
    host_if.wr_en   = 1'b0;
    host_if.ovf_clr = '0;
  endtask

  task automatic pulse_clr(input logic [CH-1:0] clr);
    host_if.ovf_clr = clr;
    for (int c = 0; c < CH; c++) if (clr[c]) ovf_model[c] = 1'b0;
    @(negedge clk_sys);
    host_if.ovf_clr = '0;
  endtask

  task automatic wait_idle(input int ch, input int max_cyc, input string tag);
    int n = 0;
    while ((busy[ch] || exp_q[ch].size() != 0) && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq(tag, (n >= max_cyc), 0);
  endtask

  task automatic wait_bitpos(input int ch, input int pos, input int max_cyc, input string tag);
    int n = 0;
    while (bitpos[ch] != pos && n < max_cyc) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq(tag, (n >= max_cyc), 0);
  endtask

  initial begin
    int bad, f1, f2, n, base;
    logic p;

    reset_n         = 1'b0;
    ps2_clk_in      = '1;
    host_if.wr_en   = 1'b0;
    host_if.wr_chan = '0;
    host_if.wr_data = '0;
    host_if.ovf_clr = '0;

    // Reset values
    repeat (3) @(negedge clk_sys);
    check_eq("rst_ps2_clk",  ps2_clk,  2'b11);
    check_eq("rst_ps2_data", ps2_data, 2'b11);
    check_eq("rst_full",     host_if.full, 2'b00);
    check_eq("rst_overflow", host_if.overflow, 2'b00);
    check_eq("rst_busy",     busy, 2'b00);
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (ps2_clk !== 2'b11 || ps2_data !== 2'b11 || busy !== 2'b00) bad++;
    end
    check_eq("idle_after_reset", bad, 0);

    // Single byte 0x5A on ch0
    do_write(0, 8'h5A, '0);
    bad = 0; f1 = -1; f2 = -1; p = ps2_clk[0];
    for (n = 0; n < 200 && f2 < 0; n++) begin
      @(negedge clk_sys);
      if (p && !ps2_clk[0]) begin
        if (f1 < 0) f1 = n; else f2 = n;
      end
      p = ps2_clk[0];
      if (ps2_clk[1] !== 1'b1 || ps2_data[1] !== 1'b1) bad++;
    end
    check_eq("clk_period", f2 - f1, 10);
    wait_idle(0, 300, "single_timeout");
    check_eq("frame_5a_bits", {21'd0, last_frame[0]}, 32'h6B4);
    check_eq("ch1_quiet", bad, 0);
    check_eq("single_frames", frames[0], 1);
    check_eq("single_ch1_frames", frames[1], 0);

    // Fill ch1, overflow, clear
    for (int i = 1; i <= 8; i++) begin
      do_write(1, 8'(i), '0);
      check_eq($sformatf("full_after_%0d", i), host_if.full[1], (i == 8));
    end
    do_write(1, 8'h09, '0);
    check_eq("ovf_set",     host_if.overflow[1], ovf_model[1]);
    check_eq("ovf_ch0_clr", host_if.overflow[0], ovf_model[0]);
    check_eq("full_kept",   host_if.full[1], 1'b1);
    pulse_clr(2'b10);
    check_eq("ovf_cleared", host_if.overflow[1], ovf_model[1]);
    do_write(1, 8'h0A, 2'b10);
    check_eq("ovf_set_wins", host_if.overflow[1], ovf_model[1]);
    pulse_clr(2'b10);
    check_eq("ovf_cleared2", host_if.overflow[1], ovf_model[1]);
    wait_idle(1, 1500, "drain_timeout");
    check_eq("drain_frames", frames[1], 8);
    check_eq("drain_not_full", host_if.full[1], 1'b0);

    // Parallel channels
    par_en = 1'b1;
    do_write(0, 8'hFF, '0);
    do_write(1, 8'h00, '0);
    wait_idle(0, 400, "par0_timeout");
    wait_idle(1, 400, "par1_timeout");
    par_en = 1'b0;
    check_eq("par_overlap",  (overlap > 0), 1);
    check_eq("par_phase",    phase_err, 0);
    check_eq("par_parity0",  last_frame[0][9], 1'b1);
    check_eq("par_parity1",  last_frame[1][9], 1'b1);

    // Reset during D3
    do_write(0, 8'h33, '0);
    do_write(0, 8'h44, '0);
    wait_bitpos(0, 5, 300, "d3_timeout");
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_clk",  ps2_clk,  2'b11);
    check_eq("midrst_data", ps2_data, 2'b11);
    check_eq("midrst_busy", busy, 2'b00);
    exp_q[0].delete();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    base = frames[0];
    bad = 0;
    repeat (60) begin
      @(negedge clk_sys);
      if (busy[0] !== 1'b0 || ps2_clk[0] !== 1'b1) bad++;
    end
    check_eq("midrst_fifo_empty", bad, 0);
    check_eq("midrst_no_frames", frames[0] - base, 0);

`ifdef PS2_TX_INHIBIT_EN
    // Host inhibit during D4, then retry
    base = frames[0];
    do_write(0, 8'hA5, '0);
    wait_bitpos(0, 6, 300, "d4_timeout");
    ps2_clk_in[0] = 1'b0;
    n = 0;
    while (busy[0] && n < 30) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("inh_abort_timeout", (n >= 30), 0);
    check_eq("inh_data_high", ps2_data[0], 1'b1);
    bad = 0;
    repeat (40) begin
      @(negedge clk_sys);
      if (busy[0] !== 1'b0) bad++;
    end
    check_eq("inh_no_start", bad, 0);
    ps2_clk_in[0] = 1'b1;
    wait_idle(0, 400, "inh_retry_timeout");
    check_eq("inh_retry_frames", frames[0] - base, 1);
    check_eq("inh_retry_bits", {21'd0, last_frame[0]}, {21'd0, frame_bits(8'hA5)});
`endif

    check_eq("end_full", host_if.full, 2'b00);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
